// File: rtl/taillight_pkg.sv
// Shared mode encodings, lamp pattern constants and decode helpers for the
// taillight sequencer.
package taillight_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_LEFT   = 3'd1,
        MODE_RIGHT  = 3'd2,
        MODE_LBREAK = 3'd3,
        MODE_RBREAK = 3'd4,
        MODE_BREAK  = 3'd5,
        MODE_HAZARD = 3'd6
    } mode_e;

    localparam logic [2:0] PAT_OFF = '0;
    localparam logic [2:0] PAT_ALL = '1;

    // Code 7 is unassigned and behaves exactly like IDLE.
    function automatic logic is_idle(input logic [2:0] m);
        return (m == MODE_IDLE) || (m == 3'd7);
    endfunction

    function automatic logic [2:0] turn_pat(input logic [1:0] s);
        logic [2:0] p;
        case (s)
            2'd0:    p = 3'b000;
            2'd1:    p = 3'b001;
            2'd2:    p = 3'b011;
            default: p = 3'b111;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/taillight_sequencer_tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags the wrap cycle; clr restarts the period.
module tick_gen #(
    parameter int DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A clear in the wrap cycle suppresses the tick so the period restarts cleanly.
    always_comb begin
        tick  = (cnt_q == CNT_MAX) && !clr;
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Taillight sequencer: mode register, 4-step sequence counter and registered
// lamp decode, advanced by the tick_gen prescaler.
module taillight_sequencer
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [2:0] mode,
    output logic [2:0] lights_l,
    output logic [2:0] lights_r,
    output logic       step
);

    logic [2:0] mode_q, mode_d;
    logic [1:0] seq_q, seq_d;
    logic [2:0] lights_l_q, lights_l_d;
    logic [2:0] lights_r_q, lights_r_d;
    logic       step_q, step_d;
    logic       change, clr, tick;

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        mode_d = mode;
        change = (mode != mode_q);
        clr    = change || is_idle(mode_q);
        step_d = tick;

        seq_d = seq_q;
        if (clr) begin
            seq_d = '0;
        end else if (tick) begin
            seq_d = seq_q + 2'd1;
        end

        // Lamps decode from the registered mode and sequence, one edge behind.
        lights_l_d = PAT_OFF;
        lights_r_d = PAT_OFF;
        case (mode_q)
            MODE_LEFT: begin
                lights_l_d = turn_pat(seq_q);
            end
            MODE_RIGHT: begin
                lights_r_d = turn_pat(seq_q);
            end
            MODE_LBREAK: begin
                lights_l_d = turn_pat(seq_q);
                lights_r_d = PAT_ALL;
            end
            MODE_RBREAK: begin
                lights_l_d = PAT_ALL;
                lights_r_d = turn_pat(seq_q);
            end
            MODE_BREAK: begin
                lights_l_d = PAT_ALL;
                lights_r_d = PAT_ALL;
            end
            MODE_HAZARD: begin
                lights_l_d = seq_q[0] ? PAT_ALL : PAT_OFF;
                lights_r_d = seq_q[0] ? PAT_ALL : PAT_OFF;
            end
            default: begin
                lights_l_d = PAT_OFF;
                lights_r_d = PAT_OFF;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            mode_q     <= MODE_IDLE;
            seq_q      <= '0;
            lights_l_q <= PAT_OFF;
            lights_r_q <= PAT_OFF;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            seq_q      <= seq_d;
            lights_l_q <= lights_l_d;
            lights_r_q <= lights_r_d;
            step_q     <= step_d;
        end
    end

    assign lights_l = lights_l_q;
    assign lights_r = lights_r_q;
    assign step     = step_q;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Bench for taillight_sequencer: directed scenarios plus randomized mode/reset
// traffic compared each cycle against a time-based reference model.
module tb_taillight_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [2:0] lights_l, lights_r;
    logic       step;

    int errors = 0;
    int checks = 0;

    // Reference model: edges since the current mode was latched determine
    // the sequence position; nothing else is tracked.
    int         edge_n  = 0;
    int         m_start = 0;
    logic [2:0] m_mode  = 3'd0;
    logic [2:0] exp_l, exp_r;
    logic       exp_step;
    logic [7:0] exp_seq, exp_cnt;

    taillight_sequencer #(
        .TICK_DIV(DIV)
    ) dut (
        .CLOCK_50(clk),
        .rst     (rst),
        .mode    (mode),
        .lights_l(lights_l),
        .lights_r(lights_r),
        .step    (step)
    );

    always #5 clk = ~clk;

    function automatic bit m_idle(input logic [2:0] m);
        return (m == 3'd0) || (m == 3'd7);
    endfunction

    function automatic logic [5:0] lamps(input logic [2:0] m, input int s);
        logic [2:0] turn, haz;
        turn = 3'((1 << s) - 1);
        haz  = (s % 2 == 1) ? 3'b111 : 3'b000;
        case (m)
            3'd1:    return {turn, 3'b000};
            3'd2:    return {3'b000, turn};
            3'd3:    return {turn, 3'b111};
            3'd4:    return {3'b111, turn};
            3'd5:    return 6'b111111;
            3'd6:    return {haz, haz};
            default: return 6'b000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at edge %0d", tag, obs, expv, edge_n);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] m);
        int prev_seq;
        rst  = r;
        mode = m;
        @(posedge clk);
        #1;
        edge_n++;
        if (r) begin
            exp_l    = 3'b000;
            exp_r    = 3'b000;
            exp_step = 1'b0;
            m_mode   = 3'd0;
        end else begin
            prev_seq = m_idle(m_mode) ? 0 : (((edge_n - 1) - m_start) / DIV) % 4;
            {exp_l, exp_r} = lamps(m_mode, prev_seq);
            exp_step = !m_idle(m_mode) && (m == m_mode) && ((edge_n - m_start) % DIV == 0);
            if (m != m_mode) begin
                m_mode  = m;
                m_start = edge_n;
            end
        end
        exp_seq = m_idle(m_mode) ? 8'd0 : 8'(((edge_n - m_start) / DIV) % 4);
        exp_cnt = m_idle(m_mode) ? 8'd0 : 8'((edge_n - m_start) % DIV);
        check("lights_l", {5'd0, lights_l}, {5'd0, exp_l});
        check("lights_r", {5'd0, lights_r}, {5'd0, exp_r});
        check("step", {7'd0, step}, {7'd0, exp_step});
        check("seq", {6'd0, dut.seq_q}, exp_seq);
        check("cnt", {6'd0, dut.u_tick.cnt_q}, exp_cnt);
    endtask

    task automatic hold(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, m);
    endtask

    initial begin
        int len;
        logic [2:0] rm;
        rst  = 1'b1;
        mode = 3'd0;

        // Reset for two cycles, then LEFT through a full sequence and wrap.
        cyc(1'b1, 3'd0);
        cyc(1'b1, 3'd0);
        hold(3'd1, 22);

        // LBREAK to seq 2, then RBREAK mid-sequence.
        hold(3'd0, 2);
        hold(3'd3, 10);
        check("seq_before_switch", {6'd0, dut.seq_q}, 8'd2);
        hold(3'd4, 3);
        check("rbreak_lights_l", {5'd0, lights_l}, 8'd7);
        check("rbreak_lights_r", {5'd0, lights_r}, 8'd0);
        hold(3'd4, 6);

        // HAZARD toggling, then BREAK steady.
        hold(3'd6, 18);
        hold(3'd5, 20);

        // Change exactly in the wrap cycle: latch LEFT, hold it through cnt=3.
        hold(3'd1, 4);
        check("cnt_at_wrap", {6'd0, dut.u_tick.cnt_q}, 8'd3);
        hold(3'd2, 9);

        // One-cycle reset while LEFT sits at seq 3.
        hold(3'd0, 1);
        hold(3'd1, 13);
        check("seq3_before_rst", {6'd0, dut.seq_q}, 8'd3);
        cyc(1'b1, 3'd1);
        hold(3'd1, 10);

        // Code 7 behaves as IDLE.
        hold(3'd7, 12);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            rm  = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) cyc(1'b1, rm);
            hold(rm, len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/taillight_sequencer.md
TAILLIGHT_SEQUENCER -- requirements
Module: taillight_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, giving the number of CLOCK_50 cycles per sequence step (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; it is synchronous and active-high.
REQ-004 SHALL have port mode  in  3  light mode: IDLE=0, LEFT=1, RIGHT=2, LBREAK=3, RBREAK=4, BREAK=5, HAZARD=6; code 7 is treated as IDLE.
REQ-005 SHALL have port lights_l  out  3  left lamp group; bit0 is the innermost lamp and bit2 the outermost.
REQ-006 SHALL have port lights_r  out  3  right lamp group; bit0 is the innermost lamp and bit2 the outermost.
REQ-007 SHALL have port step  out  1  one-cycle pulse, high on the cycle the prescaler wraps.

Function
REQ-008 SHALL register mode into mode_q every cycle.
REQ-009 SHALL treat a cycle where mode differs from mode_q as a "change" cycle.
REQ-010 SHALL use a prescaler counter cnt that counts 0 to TICK_DIV-1, wraps to 0, and is sized with clog2(TICK_DIV) bits.
REQ-011 SHALL assert the tick internally when cnt equals TICK_DIV-1, and SHALL register step from the tick.
REQ-012 SHALL use a 2-bit sequence counter seq that increments on each tick and wraps from 3 to 0.
REQ-013 SHALL clear both cnt and seq to 0 on a change cycle; change takes priority over a tick in the same cycle.
REQ-014 SHALL hold cnt and seq at 0 while mode_q is IDLE or 7.
REQ-015 SHALL compute the turn pattern from seq: 0 gives 000, 1 gives 001, 2 gives 011, 3 gives 111.
REQ-016 SHALL drive LEFT as lights_l = turn pattern and lights_r = 000.
REQ-017 SHALL drive RIGHT as lights_r = turn pattern and lights_l = 000.
REQ-018 SHALL drive LBREAK as lights_l = turn pattern and lights_r = 111.
REQ-019 SHALL drive RBREAK as lights_r = turn pattern and lights_l = 111.
REQ-020 SHALL drive BREAK as both groups = 111, steady, independent of seq.
REQ-021 SHALL drive HAZARD as both groups = 111 when seq[0] is 1 and 000 otherwise, so the lamps toggle once per tick.
REQ-022 SHALL drive IDLE and code 7 as both groups = 000.
REQ-023 SHALL register lights_l and lights_r from mode_q and seq.
REQ-024 SHALL show a mode applied before edge n on the lights after edge n+1, i.e. two-edge latency, with seq = 0 at that point.
REQ-025 SHALL not change the lights when mode is held constant, except at tick boundaries, one cycle after step.

Reset
REQ-026 SHALL, when rst is sampled high, set mode_q to IDLE, cnt to 0, seq to 0, lights_l and lights_r to 000, and step to 0 on that edge.
REQ-027 SHALL give rst priority over change, tick and mode decoding.
REQ-028 SHALL, after rst deasserts, restart a non-IDLE mode from seq = 0 with a full TICK_DIV period before the first step.

Structure
REQ-029 SHALL take the mode encodings (IDLE through HAZARD) from shared package taillight_pkg, which the next-state logic block also uses.
REQ-030 SHALL place the pattern constants PAT_OFF = 000 and PAT_ALL = 111 in taillight_pkg.
REQ-031 SHALL implement the prescaler as sub-module tick_gen with parameter DIV, inputs CLOCK_50, rst and clr, and output tick.
REQ-032 SHALL place the seq counter, mode register and output decode in taillight_sequencer.

Verification (TICK_DIV=4)
REQ-033 SHALL verify: rst for 2 cycles, then mode=1 held -> lights_l steps 000, 001, 011, 111, 000 with 4 cycles per step, lights_r = 000 throughout, and step pulses every 4 cycles.
REQ-034 SHALL verify: mode=3 held -> lights_r = 111 constant while lights_l runs the turn pattern; then switch to mode=4 mid-sequence at seq=2 -> two edges later lights_l = 111 and lights_r = 000, restarting from seq 0.
REQ-035 SHALL verify: mode=6 -> both groups 000 for 4 cycles, then 111 for 4 cycles, repeating; and mode=5 -> both groups 111 steady, with no toggle across 20 cycles.
REQ-036 SHALL verify: mode change in the same cycle as a tick -> seq reads 0, not incremented, and the next step follows 4 cycles after the change.
REQ-037 SHALL verify: rst pulsed for 1 cycle while LEFT is at seq=3 -> lights 000 on the next edge, then the sequence restarts at 000 with the first advance 4 cycles after rst falls.
REQ-038 SHALL verify: mode=7 -> both groups 000, step never asserted, and cnt held at 0.
